dmem_host_port: RTL

- Host-side loader/unloader for the single-cycle core's data memory.
- Holds the core in reset while streaming a byte image into dmem, then releases the core and waits for `done`.
- After completion it streams a configurable dmem window back out to the host.
- It is the host/testbench end of the core's dmem and done/reset interface.

---
 rtl/dmem_host_port_if.sv | 30 +++
 rtl/dmem_host_port.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_host_port_if.sv
// Host byte stream and dmem port bundle for dmem_host_port.
// master = the port block itself, slave = host/testbench and memory side.
interface dmem_host_port_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // Both streams use valid/ready: a transfer happens in every cycle where
  // valid and ready are both high at the rising clock edge. The producer
  // keeps data stable while valid is high and ready is low.
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_di;
  logic [DW-1:0] dm_dout;

  modport master (
    input  in_valid, in_data, out_ready, dm_dout,
    output in_ready, out_valid, out_data, dm_we, dm_addr, dm_di
  );

  modport slave (
    output in_valid, in_data, out_ready, dm_dout,
    input  in_ready, out_valid, out_data, dm_we, dm_addr, dm_di
  );
endinterface

// File: rtl/dmem_host_port.sv
// Host-side data-memory loader/unloader: loads an image with the core held in
// reset, runs the core until done (or timeout), then dumps a dmem window.
module dmem_host_port #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RUN_GUARD = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [AW-1:0]  cfg_load_len,
  input  logic [AW-1:0]  cfg_dump_base,
  input  logic [AW-1:0]  cfg_dump_len,
  dmem_host_port_if.master bus,
  output logic           cpu_reset,
  input  logic           cpu_done,
  output logic           busy,
  output logic           timeout,
  output logic           finished,
  output logic [1:0]     dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   run_cnt_q, run_cnt_d;
  logic [AW-1:0] load_len_q, load_len_d;
  logic [AW-1:0] dump_base_q, dump_base_d;
  logic [AW-1:0] dump_len_q, dump_len_d;
  logic          timeout_q, timeout_d;
  logic          finished_q, finished_d;

  logic load_hs, dump_hs, done_ok, expired;

  assign load_hs = (state_q == S_LOAD) && bus.in_valid;
  assign dump_hs = (state_q == S_DUMP) && bus.out_ready;
  assign done_ok = cpu_done && (run_cnt_q >= 16'(RUN_GUARD));
  // The run is aborted at the end of its TIMEOUT-th cycle.
  assign expired = (run_cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    load_len_d  = load_len_q;
    dump_base_d = dump_base_q;
    dump_len_d  = dump_len_q;
    timeout_d   = timeout_q;
    finished_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_len_d  = cfg_load_len;
          dump_base_d = cfg_dump_base;
          dump_len_d  = cfg_dump_len;
          timeout_d   = 1'b0;
          idx_d       = '0;
          run_cnt_d   = '0;
          state_d     = (cfg_load_len != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          if (idx_q == load_len_q - 1'b1) begin
            idx_d     = '0;
            run_cnt_d = '0;
            state_d   = S_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 16'd1;
        if (done_ok || expired) begin
          if (!done_ok) timeout_d = 1'b1;
          idx_d      = '0;
          state_d    = (dump_len_q != '0) ? S_DUMP : S_IDLE;
          finished_d = (dump_len_q == '0);
        end
      end
      default: begin
        if (dump_hs) begin
          if (idx_q == dump_len_q - 1'b1) begin
            idx_d      = '0;
            state_d    = S_IDLE;
            finished_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      run_cnt_q   <= '0;
      load_len_q  <= '0;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      timeout_q   <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
      load_len_q  <= load_len_d;
      dump_base_q <= dump_base_d;
      dump_len_q  <= dump_len_d;
      timeout_q   <= timeout_d;
      finished_q  <= finished_d;
    end
  end

  // Memory-side outputs are decoded from the current state so the load write
  // and the dump read both happen in the handshake cycle itself.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_di     = '0;
    case (state_q)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.dm_addr  = idx_q;
        if (bus.in_valid) begin
          bus.dm_we = 1'b1;
          bus.dm_di = bus.in_data;
        end
      end
      S_DUMP: begin
        bus.out_valid = 1'b1;
        bus.dm_addr   = dump_base_q + idx_q;
        bus.out_data  = bus.dm_dout;
      end
      default: ;
    endcase
  end

  assign cpu_reset   = (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign timeout     = timeout_q;
  assign finished    = finished_q;
  assign dbg_state_o = state_q;

endmodule
